wb_port_arbiter: RTL and testbench

- Arbitrates the single register-file write port of the 16-bit, 8-register pipeline.
- Two sources compete for the port:
  - the MEM/WB writeback stage, which has absolute priority and no backpressure;
  - a multi-cycle auxiliary unit (mul/div), whose results are buffered in a small FIFO.
- Also publishes a per-register pending scoreboard for the hazard unit, and raises a stall request when auxiliary results starve.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_port_arbiter_fifo.sv | 68 ++++++
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// The macro WBARB_WAW_SQUASH_EN (used by wb_port_arbiter) enables squashing of
// stale queued aux results when the pipe writes the same register.
package wb_arb_pkg;

  localparam int ARB_DATA_W = 16;
  localparam int ARB_ADDR_W = 3;

  typedef struct packed {
    logic                  valid;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } aux_entry_t;

  function automatic logic [2**ARB_ADDR_W-1:0] oneHotDecode(input logic [ARB_ADDR_W-1:0] addr);
    oneHotDecode = '0;
    oneHotDecode[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_aux_fifo: small circular buffer of auxiliary results awaiting the write port.
// Entries can be invalidated in place by address; a popped slot always has its
// valid bit cleared, so pendingMask can simply OR over every slot.
module wb_aux_fifo
  import wb_arb_pkg::*;
#(
  parameter int Q_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  aux_entry_t              pushEntry,
  input  logic                    pop,
  input  logic                    clrEn,
  input  logic [ARB_ADDR_W-1:0]   clrAddr,
  output aux_entry_t              head,
  output logic                    full,
  output logic                    empty,
  output logic [2**ARB_ADDR_W-1:0] pendingMask
);

  localparam int PTR_W = $clog2(Q_DEPTH);

  aux_entry_t       mem [Q_DEPTH];
  logic [PTR_W:0]   wrPtr;
  logic [PTR_W:0]   rdPtr;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                 (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign head  = mem[rdPtr[PTR_W-1:0]];

  // Pointer and storage update: address-match invalidation, pop, push
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        if (clrEn && (mem[i].addr == clrAddr)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem[rdPtr[PTR_W-1:0]].valid <= 1'b0;
        rdPtr <= rdPtr + 1'b1;
      end
      if (push) begin
        mem[wrPtr[PTR_W-1:0]] <= pushEntry;
        wrPtr <= wrPtr + 1'b1;
      end
    end
  end

  // Registers targeted by still-valid queued entries
  always_comb begin
    pendingMask = '0;
    for (int unsigned i = 0; i < Q_DEPTH; i++) begin
      if (mem[i].valid) begin
        pendingMask = pendingMask | oneHotDecode(mem[i].addr);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: single register-file write port shared by the MEM/WB stage
// (absolute priority) and a queued auxiliary unit, with starvation stall request.
// Optional macro WBARB_WAW_SQUASH_EN: a pipe write invalidates queued or
// same-cycle aux results to the same register.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = ARB_DATA_W,
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int Q_DEPTH    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_regwrite,
  input  logic                 pipe_memtoreg,
  input  logic [DATA_W-1:0]    pipe_readdata,
  input  logic [DATA_W-1:0]    pipe_aluresult,
  input  logic [ADDR_W-1:0]    pipe_wreg,
  input  logic                 aux_valid,
  output logic                 aux_ready,
  input  logic [ADDR_W-1:0]    aux_wreg,
  input  logic [DATA_W-1:0]    aux_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 stall_req,
  output logic [2**ADDR_W-1:0] pending_mask
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  aux_entry_t          head;
  aux_entry_t          pushEntry;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                clrEn;
  logic                accept;
  logic                headValid;
  logic                hasValid;
  logic                squashIn;
  logic                useHead;
  logic                useBypass;
  logic                weNext;
  logic [ADDR_W-1:0]   addrNext;
  logic [DATA_W-1:0]   dataNext;
  logic [DATA_W-1:0]   pipeData;
  logic [CNT_W-1:0]    starveCnt;

  assign aux_ready = !rst && !full;
  assign accept    = aux_valid && aux_ready;
  assign pipeData  = pipe_memtoreg ? pipe_readdata : pipe_aluresult;
  assign headValid = !empty && head.valid;
  assign hasValid  = |pending_mask;
  assign stall_req = (starveCnt == CNT_W'(STARVE_MAX));

`ifdef WBARB_WAW_SQUASH_EN
  assign clrEn    = pipe_regwrite;
  assign squashIn = accept && pipe_regwrite && (aux_wreg == pipe_wreg);
`else
  assign clrEn    = 1'b0;
  assign squashIn = 1'b0;
`endif

  wb_aux_fifo #(
    .Q_DEPTH(Q_DEPTH)
  ) auxFifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pushEntry  (pushEntry),
    .pop        (pop),
    .clrEn      (clrEn),
    .clrAddr    (pipe_wreg),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .pendingMask(pending_mask)
  );

  // Port selection: pipe, then valid head, then bypass into an empty queue
  always_comb begin
    weNext    = 1'b0;
    addrNext  = '0;
    dataNext  = '0;
    useHead   = 1'b0;
    useBypass = 1'b0;
    if (pipe_regwrite) begin
      weNext   = 1'b1;
      addrNext = pipe_wreg;
      dataNext = pipeData;
    end else if (headValid) begin
      weNext   = 1'b1;
      useHead  = 1'b1;
      addrNext = head.addr;
      dataNext = head.data;
    end else if (empty && accept) begin
      weNext    = 1'b1;
      useBypass = 1'b1;
      addrNext  = aux_wreg;
      dataNext  = aux_data;
    end
    // An invalid head is discarded without touching the port
    pop             = !empty && (useHead || !head.valid);
    push            = accept && !useBypass;
    pushEntry.valid = !squashIn;
    pushEntry.addr  = aux_wreg;
    pushEntry.data  = aux_data;
  end

  // Registered write port; address/data hold when no write is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= weNext;
      if (weNext) begin
        rf_waddr <= addrNext;
        rf_wdata <= dataNext;
      end
    end
  end

  // Starvation counter: counts cycles a valid head loses to the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (useHead || !hasValid) begin
      starveCnt <= '0;
    end else if (headValid && pipe_regwrite && !stall_req) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expectations follow WBARB_WAW_SQUASH_EN.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeRegwrite;
  logic        pipeMemtoreg;
  logic [15:0] pipeReaddata;
  logic [15:0] pipeAluresult;
  logic [2:0]  pipeWreg;
  logic        auxValid;
  logic        auxReady;
  logic [2:0]  auxWreg;
  logic [15:0] auxData;
  logic        rfWe;
  logic [2:0]  rfWaddr;
  logic [15:0] rfWdata;
  logic        stallReq;
  logic [7:0]  pendingMask;

  int checkCnt = 0;
  int errCnt   = 0;

  wb_port_arbiter #(
    .DATA_W    (16),
    .ADDR_W    (3),
    .Q_DEPTH   (2),
    .STARVE_MAX(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_regwrite (pipeRegwrite),
    .pipe_memtoreg (pipeMemtoreg),
    .pipe_readdata (pipeReaddata),
    .pipe_aluresult(pipeAluresult),
    .pipe_wreg     (pipeWreg),
    .aux_valid     (auxValid),
    .aux_ready     (auxReady),
    .aux_wreg      (auxWreg),
    .aux_data      (auxData),
    .rf_we         (rfWe),
    .rf_waddr      (rfWaddr),
    .rf_wdata      (rfWdata),
    .stall_req     (stallReq),
    .pending_mask  (pendingMask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPipe(input logic we, input logic mtr, input logic [15:0] rd,
                         input logic [15:0] alu, input logic [2:0] wreg);
    pipeRegwrite  = we;
    pipeMemtoreg  = mtr;
    pipeReaddata  = rd;
    pipeAluresult = alu;
    pipeWreg      = wreg;
  endtask

  task automatic setAux(input logic v, input logic [2:0] wreg, input logic [15:0] data);
    auxValid = v;
    auxWreg  = wreg;
    auxData  = data;
  endtask

  initial begin
    rst = 1'b1;
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    setAux(1'b0, 3'd0, 16'h0);
    #1;
    chk("readyInReset", 32'(auxReady), 32'd0);
    tick();
    tick();
    chk("rstWe", 32'(rfWe), 32'd0);
    chk("rstAddr", 32'(rfWaddr), 32'd0);
    chk("rstData", 32'(rfWdata), 32'd0);
    chk("rstStall", 32'(stallReq), 32'd0);
    chk("rstPending", 32'(pendingMask), 32'd0);
    rst = 1'b0;
    #1;
    chk("readyAfterRst", 32'(auxReady), 32'd1);

    // Pipe writes: load data then ALU result
    setPipe(1'b1, 1'b1, 16'hBEEF, 16'h1234, 3'd3);
    tick();
    chk("loadWe", 32'(rfWe), 32'd1);
    chk("loadAddr", 32'(rfWaddr), 32'd3);
    chk("loadData", 32'(rfWdata), 32'hBEEF);
    setPipe(1'b1, 1'b0, 16'hBEEF, 16'h1234, 3'd2);
    tick();
    chk("aluAddr", 32'(rfWaddr), 32'd2);
    chk("aluData", 32'(rfWdata), 32'h1234);

    // Bypass into an empty queue with the pipe idle
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    setAux(1'b1, 3'd5, 16'h0042);
    tick();
    chk("bypWe", 32'(rfWe), 32'd1);
    chk("bypAddr", 32'(rfWaddr), 32'd5);
    chk("bypData", 32'(rfWdata), 32'h0042);
    chk("bypPending", 32'(pendingMask), 32'd0);
    setAux(1'b0, 3'd0, 16'h0);
    tick();
    chk("idleWe", 32'(rfWe), 32'd0);

    // Starvation: pipe busy while r1, r2 queue up
    setPipe(1'b1, 1'b0, 16'h0, 16'h0700, 3'd7);
    setAux(1'b1, 3'd1, 16'h1111);
    tick();
    chk("q1Pending", 32'(pendingMask), 32'h02);
    chk("q1Ready", 32'(auxReady), 32'd1);
    setAux(1'b1, 3'd2, 16'h2222);
    tick();
    chk("q2Ready", 32'(auxReady), 32'd0);
    chk("q2Pending", 32'(pendingMask), 32'h06);
    setAux(1'b0, 3'd0, 16'h0);
    tick();
    tick();
    chk("stallNotYet", 32'(stallReq), 32'd0);
    tick();
    chk("stallUp", 32'(stallReq), 32'd1);
    chk("pipeStillWins", 32'(rfWaddr), 32'd7);
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("fullPopReady", 32'(auxReady), 32'd0);
    tick();
    chk("headWe", 32'(rfWe), 32'd1);
    chk("headAddr", 32'(rfWaddr), 32'd1);
    chk("headData", 32'(rfWdata), 32'h1111);
    chk("stallClear", 32'(stallReq), 32'd0);
    chk("readyBack", 32'(auxReady), 32'd1);
    chk("pendAfterPop", 32'(pendingMask), 32'h04);
    tick();
    chk("secondAddr", 32'(rfWaddr), 32'd2);
    chk("secondData", 32'(rfWdata), 32'h2222);
    chk("drainPending", 32'(pendingMask), 32'd0);
    tick();
    chk("drainIdle", 32'(rfWe), 32'd0);

    // Queued r4, then pipe writes r4
    setPipe(1'b1, 1'b0, 16'h0, 16'h0001, 3'd0);
    setAux(1'b1, 3'd4, 16'h4444);
    tick();
    chk("r4Pending", 32'(pendingMask), 32'h10);
    setAux(1'b0, 3'd0, 16'h0);
    setPipe(1'b1, 1'b0, 16'h0, 16'hAAAA, 3'd4);
    tick();
    chk("r4PipeAddr", 32'(rfWaddr), 32'd4);
    chk("r4PipeData", 32'(rfWdata), 32'hAAAA);
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
`ifdef WBARB_WAW_SQUASH_EN
    chk("r4Squashed", 32'(pendingMask), 32'd0);
    tick();
    chk("r4NoAuxWe", 32'(rfWe), 32'd0);
`else
    chk("r4Kept", 32'(pendingMask), 32'h10);
    tick();
    chk("r4AuxWe", 32'(rfWe), 32'd1);
    chk("r4AuxData", 32'(rfWdata), 32'h4444);
`endif
    tick();
    chk("r4Done", 32'(rfWe), 32'd0);
    chk("r4DonePend", 32'(pendingMask), 32'd0);

    // Same-cycle pipe and aux to r6
    setPipe(1'b1, 1'b0, 16'h0, 16'h6666, 3'd6);
    setAux(1'b1, 3'd6, 16'h0606);
    tick();
    chk("r6PipeData", 32'(rfWdata), 32'h6666);
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    setAux(1'b0, 3'd0, 16'h0);
`ifdef WBARB_WAW_SQUASH_EN
    chk("r6Pending", 32'(pendingMask), 32'd0);
    tick();
    chk("r6NoAuxWe", 32'(rfWe), 32'd0);
    chk("r6KeepData", 32'(rfWdata), 32'h6666);
`else
    chk("r6Pending", 32'(pendingMask), 32'h40);
    tick();
    chk("r6AuxWe", 32'(rfWe), 32'd1);
    chk("r6AuxData", 32'(rfWdata), 32'h0606);
`endif
    tick();

    // Reset with two queued entries
    setPipe(1'b1, 1'b0, 16'h0, 16'h0003, 3'd0);
    setAux(1'b1, 3'd3, 16'h3333);
    tick();
    setAux(1'b1, 3'd5, 16'h5555);
    tick();
    chk("preRstPending", 32'(pendingMask), 32'h28);
    setAux(1'b0, 3'd0, 16'h0);
    rst = 1'b1;
    #1;
    chk("midRstReady", 32'(auxReady), 32'd0);
    tick();
    chk("midRstWe", 32'(rfWe), 32'd0);
    chk("midRstAddr", 32'(rfWaddr), 32'd0);
    chk("midRstData", 32'(rfWdata), 32'd0);
    chk("midRstPending", 32'(pendingMask), 32'd0);
    chk("midRstStall", 32'(stallReq), 32'd0);
    rst = 1'b0;
    setPipe(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    chk("postRstReady", 32'(auxReady), 32'd1);
    tick();
    chk("postRstWe", 32'(rfWe), 32'd0);
    chk("postRstPending", 32'(pendingMask), 32'd0);
    chk("postRstAddr", 32'(rfWaddr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
